// File: rtl/stoch_div_mat_seq.sv
// stoch_div_mat_seq: clear / warm-up / count / present sequencer for a stochastic divider array
//   CLK, RST        rising-edge clock, synchronous active-high reset
//   start, abort    run request (registered, honoured only in IDLE) and run cancel
//   busy            high while clearing, warming up or counting
//   div_nrst        registered active-low reset to the divider array
//   stream_en       enable to the bitstream generators during warm-up and counting
//   div_y           row-major divider outputs, element e = i*NUM_COLS+j
//   out_valid/ready count handshake; counts holds element e at [e*CNT_WIDTH +: CNT_WIDTH]
module stoch_div_mat_seq #(
   parameter int NUM_ROWS   = 2,
   parameter int NUM_COLS   = 2,
   parameter int STREAM_LEN = 256,
   parameter int WARMUP     = 16,
   parameter int CNT_WIDTH  = 9
) (
   input  logic                                   CLK,
   input  logic                                   RST,
   input  logic                                   start,
   input  logic                                   abort,
   output logic                                   busy,
   output logic                                   div_nrst,
   output logic                                   stream_en,
   input  logic [NUM_ROWS*NUM_COLS-1:0]           div_y,
   output logic                                   out_valid,
   input  logic                                   out_ready,
   output logic [NUM_ROWS*NUM_COLS*CNT_WIDTH-1:0] counts
);
   localparam int N    = NUM_ROWS * NUM_COLS;
   localparam int LMAX = STREAM_LEN > WARMUP ? STREAM_LEN : WARMUP;
   localparam int TW   = $clog2(LMAX + 1);
   if ((2 ** CNT_WIDTH) <= STREAM_LEN) begin : g_cnt_chk
      $error("stoch_div_mat_seq: 2**CNT_WIDTH must exceed STREAM_LEN");
   end
   if (STREAM_LEN < 1) begin : g_len_chk
      $error("stoch_div_mat_seq: STREAM_LEN must be at least 1");
   end
   typedef enum logic [2:0] {IDLE, CLEAR, WARM, RUN, DONE} state_e;
   state_e               state_q, state_d;
   logic [TW-1:0]        tmr_q, tmr_d;
   logic                 start_q, nrst_q, clr;
   logic [N*CNT_WIDTH-1:0] cnt_q, cnt_d;
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = start_q ? CLEAR : IDLE;
         CLEAR:   state_d = WARMUP > 0 ? WARM : RUN;
         WARM:    state_d = tmr_q == TW'(WARMUP - 1) ? RUN : WARM;
         RUN:     state_d = tmr_q == TW'(STREAM_LEN - 1) ? DONE : RUN;
         DONE:    state_d = out_ready ? IDLE : DONE;
         default: state_d = IDLE;
      endcase
      if (abort && state_q != IDLE) state_d = IDLE;
      // the phase timer restarts on every state change, so CLEAR always sees zero
      tmr_d = state_d != state_q ? '0 : tmr_q + 1'b1;
      // counts read zero during CLEAR itself and right after an abort
      clr   = state_d == CLEAR || (abort && state_q != IDLE);
      cnt_d = cnt_q;
      for (int e = 0; e < N; e++)
         cnt_d[e*CNT_WIDTH +: CNT_WIDTH] = clr ? '0 :
            cnt_q[e*CNT_WIDTH +: CNT_WIDTH] + CNT_WIDTH'(state_q == RUN && div_y[e]);
   end
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         tmr_q   <= '0;
         start_q <= 1'b0;
         nrst_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
         // start is registered and only captured in IDLE, so requests made while busy are dropped
         start_q <= start && state_q == IDLE;
         nrst_q  <= state_d != CLEAR;
         cnt_q   <= cnt_d;
      end
   end
   assign busy      = state_q == CLEAR || state_q == WARM || state_q == RUN;
   assign stream_en = state_q == WARM || state_q == RUN;
   assign out_valid = state_q == DONE;
   assign div_nrst  = nrst_q;
   assign counts    = cnt_q;
endmodule

// File: tb/tb_stoch_div_mat_seq.sv
// tb_stoch_div_mat_seq: randomized and directed checks of stoch_div_mat_seq against a window-sum model
module tb_stoch_div_mat_seq;
   localparam int S = 16;
   logic CLK = 1'b0, RST = 1'b1, start = 1'b0, start0 = 1'b0, abort = 1'b0, out_ready = 1'b0;
   logic [3:0] div_y = '0;
   logic busy, div_nrst, stream_en, out_valid, busy0, div_nrst0, stream_en0, out_valid0;
   logic [19:0] counts, counts0;
   logic o_b, o_n, o_s, o_v;
   logic [19:0] o_c;
   int vecs = 0, errs = 0;
   bit done;
   stoch_div_mat_seq #(.NUM_ROWS(2), .NUM_COLS(2), .STREAM_LEN(S), .WARMUP(4), .CNT_WIDTH(5)) dut (
      .CLK(CLK), .RST(RST), .start(start), .abort(abort), .busy(busy), .div_nrst(div_nrst),
      .stream_en(stream_en), .div_y(div_y), .out_valid(out_valid), .out_ready(out_ready), .counts(counts));
   stoch_div_mat_seq #(.NUM_ROWS(2), .NUM_COLS(2), .STREAM_LEN(S), .WARMUP(0), .CNT_WIDTH(5)) dut0 (
      .CLK(CLK), .RST(RST), .start(start0), .abort(abort), .busy(busy0), .div_nrst(div_nrst0),
      .stream_en(stream_en0), .div_y(div_y), .out_valid(out_valid0), .out_ready(out_ready), .counts(counts0));
   always #5 CLK = ~CLK;
   task automatic tick;
      @(posedge CLK);
      #1;
   endtask
   task automatic sample(input int w);
      o_b = w == 0 ? busy0 : busy;
      o_n = w == 0 ? div_nrst0 : div_nrst;
      o_s = w == 0 ? stream_en0 : stream_en;
      o_v = w == 0 ? out_valid0 : out_valid;
      o_c = w == 0 ? counts0 : counts;
   endtask
   task automatic chk1(input string tag, input logic obs, input logic exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
      end
   endtask
   task automatic chkc(input string tag, input logic [19:0] obs, input logic [19:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   function automatic logic [19:0] pack(input int a[4]);
      logic [19:0] p;
      for (int e = 0; e < 4; e++) p[e*5 +: 5] = 5'(a[e]);
      return p;
   endfunction
   task automatic expect_reset(input string tag);
      for (int w = 0; w <= 4; w += 4) begin
         sample(w);
         chk1({tag, "_busy"}, o_b, 1'b0);
         chk1({tag, "_stream_en"}, o_s, 1'b0);
         chk1({tag, "_out_valid"}, o_v, 1'b0);
         chk1({tag, "_div_nrst"}, o_n, 1'b0);
         chkc({tag, "_counts"}, o_c, '0);
      end
   endtask
   // One run: start is sampled at edge 0, CLEAR follows at edge 1, div_y is summed over the
   // STREAM_LEN edges after warm-up (edges w+3 .. w+S+2) and out_valid appears at edge w+S+2.
   task automatic run(input int w, input int mode, input int abort_at, input int rst_at,
                      input int hold, output bit ok);
      int acc[4];
      int last;
      int r;
      logic [3:0] y;
      bit s;
      last = w + S + 2;
      ok = 1'b0;
      for (int e = 0; e < 4; e++) acc[e] = 0;
      for (int n = 0; n <= last; n++) begin
         r = n - (w + 3);
         y = mode == 1 ? 4'($urandom) :
             mode == 2 && r >= 0 && r < S ? {r < 8, 1'b1, 1'b0, r % 2 == 0} : 4'hF;
         s = n == 0 || (mode == 1 && $urandom_range(0, 1) == 1);
         div_y = y;
         if (w == 0) start0 = s; else start = s;
         abort = n == abort_at;
         RST = n == rst_at;
         tick;
         sample(w);
         if (n == abort_at) begin
            abort = 1'b0;
            start = 1'b0;
            start0 = 1'b0;
            chk1("abort_busy", o_b, 1'b0);
            chk1("abort_stream_en", o_s, 1'b0);
            chk1("abort_div_nrst", o_n, 1'b1);
            chkc("abort_counts", o_c, '0);
            for (int k = 0; k < S + 8; k++) begin
               chk1("abort_out_valid", o_v, 1'b0);
               tick;
               sample(w);
            end
            return;
         end
         if (n == rst_at) begin
            start = 1'b0;
            start0 = 1'b0;
            for (int k = 0; k < 3; k++) begin
               expect_reset("rst_hold");
               tick;
            end
            expect_reset("rst_hold");
            RST = 1'b0;
            tick;
            sample(w);
            chk1("rst_rel_div_nrst", o_n, 1'b1);
            chk1("rst_rel_busy", o_b, 1'b0);
            return;
         end
         if (r >= 0 && r < S)
            for (int e = 0; e < 4; e++) acc[e] += int'(y[e]);
         chk1("busy", o_b, n >= 1 && n <= w + S + 1);
         chk1("stream_en", o_s, n >= 2 && n <= w + S + 1);
         chk1("div_nrst", o_n, n != 1);
         chk1("out_valid", o_v, n == last);
         if (n >= 1) chkc("counts", o_c, pack(acc));
      end
      start = 1'b0;
      start0 = 1'b0;
      out_ready = 1'b0;
      for (int h = 0; h < hold; h++) begin
         tick;
         sample(w);
         chk1("hold_out_valid", o_v, 1'b1);
         chkc("hold_counts", o_c, pack(acc));
      end
      out_ready = 1'b1;
      if (w == 0) start0 = 1'b1; else start = 1'b1;
      tick;
      sample(w);
      chk1("accept_out_valid", o_v, 1'b0);
      chk1("accept_busy", o_b, 1'b0);
      out_ready = 1'b0;
      start = 1'b0;
      start0 = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick;
         sample(w);
         chk1("idle_busy", o_b, 1'b0);
         chk1("idle_out_valid", o_v, 1'b0);
         chkc("idle_counts", o_c, pack(acc));
      end
      ok = 1'b1;
   endtask
   initial begin
      tick;
      tick;
      expect_reset("reset");
      RST = 1'b0;
      tick;
      chk1("rel_div_nrst", div_nrst, 1'b1);
      chk1("rel_div_nrst0", div_nrst0, 1'b1);
      run(4, 0, -1, -1, 0, done);
      chkc("s1_counts", counts, {5'd16, 5'd16, 5'd16, 5'd16});
      run(4, 2, -1, -1, 10, done);
      chkc("s2_counts", counts, {5'd8, 5'd16, 5'd0, 5'd8});
      run(4, 0, 4 + 7, -1, 0, done);
      chkc("s4_abort_counts", counts, '0);
      run(4, 0, -1, -1, 0, done);
      chkc("s4_rerun_counts", counts, {5'd16, 5'd16, 5'd16, 5'd16});
      run(0, 0, -1, -1, 2, done);
      chkc("s5_counts", counts0, {5'd16, 5'd16, 5'd16, 5'd16});
      run(4, 1, -1, 4 + 10, 0, done);
      run(4, 0, -1, -1, 1, done);
      chkc("s6_rerun_counts", counts, {5'd16, 5'd16, 5'd16, 5'd16});
      for (int i = 0; i < 3; i++) run(4, 1, -1, -1, $urandom_range(0, 5), done);
      for (int i = 0; i < 2; i++) run(0, 1, -1, -1, $urandom_range(0, 5), done);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
